// File: rtl/mpmc10_pkg.sv
// Shared definitions for the mpmc10 write-address generator.
package mpmc10_pkg;

  // Sequencer states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mpmc10_waddr_gen.sv
// mpmc10_waddr_gen: walks a strip-aligned write address through a burst of
// num_strips strips, advancing one strip each time the memory accepts one.
// Optional feature: define MPMC10_WADDR_WRAP_EN to add the wrap_mask port,
// which confines the increment to the masked address bits.
module mpmc10_waddr_gen
  import mpmc10_pkg::*;
#(
  parameter int AW        = 32,
  parameter int STRIP_LG2 = 4,
  parameter int SW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr_base,
  input  logic [SW-1:0] num_strips,
  input  logic          valid,
`ifdef MPMC10_WADDR_WRAP_EN
  input  logic [AW-1:0] wrap_mask,
`endif
  output logic [AW-1:0] addr,
  output logic [SW-1:0] strip_cnt,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] STEP     = {{(AW-1){1'b0}}, 1'b1} << STRIP_LG2;
  localparam logic [AW-1:0] ADDR_RST = {AW{1'b1}} >> 3;
  localparam logic [SW-1:0] ONE_S    = {{(SW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] nlat_q, nlat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Advance an address by one strip; with wrapping only masked bits move.
`ifdef MPMC10_WADDR_WRAP_EN
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                               input logic [AW-1:0] m);
    return (a & ~m) | ((a + STEP) & m);
  endfunction
`else
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return a + STEP;
  endfunction
`endif

  // Next-state, address and count computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    nlat_d  = nlat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = {addr_base[AW-1:STRIP_LG2], {STRIP_LG2{1'b0}}};
          cnt_d   = '0;
          nlat_d  = num_strips;
          state_d = (num_strips == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (valid) begin
`ifdef MPMC10_WADDR_WRAP_EN
          addr_d = next_addr(addr_q, wrap_mask);
`else
          addr_d = next_addr(addr_q);
`endif
          cnt_d  = cnt_q + ONE_S;
          if (cnt_q == nlat_q - ONE_S) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; the latched strip count needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= ADDR_RST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
    nlat_q <= nlat_d;
  end

  assign addr      = addr_q;
  assign strip_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mpmc10_waddr_gen.sv
// Testbench for mpmc10_waddr_gen: directed scenarios followed by random
// traffic, all checked against a count-based reference model.
module tb_mpmc10_waddr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr_base = '0;
  logic [5:0]  num_strips = '0;
  logic        valid = 1'b0;
  logic [31:0] addr;
  logic [5:0]  strip_cnt;
  logic        busy;
  logic        done;
`ifdef MPMC10_WADDR_WRAP_EN
  logic [31:0] wrap_mask = 32'h0000_00FF;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Reference model: a sequence is a base, a length and an accepted count.
  logic [31:0] m_base = '0;
  int unsigned m_n = 0;
  int unsigned m_cnt = 0;
  bit          m_in_seq = 1'b0;
  bit          m_rst_addr = 1'b1;
  bit          m_done = 1'b0;

  mpmc10_waddr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr_base  (addr_base),
    .num_strips (num_strips),
    .valid      (valid),
`ifdef MPMC10_WADDR_WRAP_EN
    .wrap_mask  (wrap_mask),
`endif
    .addr       (addr),
    .strip_cnt  (strip_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_addr();
    logic [31:0] a;
    if (m_rst_addr) return 32'h1FFF_FFFF;
    a = m_base + 32'(m_cnt) * 32'd16;
`ifdef MPMC10_WADDR_WRAP_EN
    return (m_base & ~wrap_mask) | (a & wrap_mask);
`else
    return a;
`endif
  endfunction

  function automatic bit exp_busy();
    return m_in_seq && (m_cnt < m_n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Update the model with the inputs sampled at this rising edge.
  task automatic model_edge();
    bit was_busy, was_done;
    was_busy = exp_busy();
    was_done = m_done;
    m_done   = 1'b0;
    if (rst) begin
      m_in_seq   = 1'b0;
      m_rst_addr = 1'b1;
      m_cnt      = 0;
      m_n        = 0;
    end else if (!was_busy && !was_done && start) begin
      m_base     = {addr_base[31:4], 4'h0};
      m_n        = num_strips;
      m_cnt      = 0;
      m_in_seq   = 1'b1;
      m_rst_addr = 1'b0;
      if (m_n == 0) m_done = 1'b1;
    end else if (was_busy && valid) begin
      m_cnt++;
      if (m_cnt == m_n) m_done = 1'b1;
    end
  endtask

  // One clock: drive inputs, let the edge pass, check every output.
  task automatic step(input bit st, input logic [31:0] b, input logic [5:0] n,
                      input bit v, input bit r);
    @(negedge clk);
    start = st; addr_base = b; num_strips = n; valid = v; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    if (done === 1'b1) done_cnt++;
    chk("addr", 64'(addr), 64'(exp_addr()));
    chk("strip_cnt", 64'(strip_cnt), 64'(m_cnt));
    chk("busy", 64'(busy), 64'(exp_busy()));
    chk("done", 64'(done), 64'(m_done));
  endtask

  initial begin
    // Reset state
    step(0, 32'h0, 6'd0, 1, 1);
    step(1, 32'h1234, 6'd3, 1, 1);
    chk("rst_addr", 64'(addr), 64'h1FFF_FFFF);
    chk("rst_busy", 64'(busy), 64'h0);

    // Three strips with valid held high
    step(0, 32'h0, 6'd0, 0, 0);
    done_cnt = 0;
    step(1, 32'h0000_1007, 6'd3, 1, 0);
    chk("base_aligned", 64'(addr), 64'h1000);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 6'd0, 1, 0);
    chk("three_addr", 64'(addr), 64'h1030);
    chk("three_cnt", 64'(strip_cnt), 64'd3);
    chk("three_done_pulses", 64'(done_cnt), 64'd1);

    // Zero strips: straight to DONE, never busy
    step(1, 32'h0000_2345, 6'd0, 0, 0);
    chk("zero_done", 64'(done), 64'h1);
    chk("zero_addr", 64'(addr), 64'h2340);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("zero_busy", 64'(busy), 64'h0);

    // Toggled valid with stray start requests during RUN
    done_cnt = 0;
    step(1, 32'h0000_4000, 6'd4, 0, 0);
    begin
      bit vseq [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) step(!vseq[i], 32'h0000_9990, 6'd9, vseq[i], 0);
    end
    chk("toggle_addr", 64'(addr), 64'h4040);
    chk("toggle_done", 64'(done), 64'h1);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("toggle_done_pulses", 64'(done_cnt), 64'd1);

    // Reset mid-run aborts without a done pulse, then a fresh run works
    done_cnt = 0;
    step(1, 32'h0000_1000, 6'd5, 0, 0);
    step(0, 32'h0, 6'd0, 1, 0);
    step(0, 32'h0, 6'd0, 1, 0);
    step(1, 32'h0000_7000, 6'd2, 1, 1);
    chk("abort_addr", 64'(addr), 64'h1FFF_FFFF);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    step(1, 32'h0000_5000, 6'd1, 0, 0);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("after_abort_addr", 64'(addr), 64'h5010);
    chk("after_abort_done", 64'(done), 64'h1);
    step(0, 32'h0, 6'd0, 0, 0);

`ifdef MPMC10_WADDR_WRAP_EN
    // Increment confined to the low byte
    step(1, 32'h0000_12F0, 6'd2, 0, 0);
    chk("wrap_a0", 64'(addr), 64'h12F0);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("wrap_a1", 64'(addr), 64'h1200);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("wrap_a2", 64'(addr), 64'h1210);
`else
    // Linear increment rolls over past all-ones
    step(1, 32'hFFFF_FFF0, 6'd2, 0, 0);
    chk("roll_a0", 64'(addr), 64'hFFFF_FFF0);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("roll_a1", 64'(addr), 64'h0);
    step(0, 32'h0, 6'd0, 1, 0);
    chk("roll_a2", 64'(addr), 64'h10);
`endif
    step(0, 32'h0, 6'd0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 3), $urandom, 6'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
